dmem_resp: RTL and testbench
============================

Name: dmem_resp

Overview:
- Responder for the core data-memory interface. It sits on the far end of dmem_addr/dmem_dt/dmem_wr.
- Decodes an 8-bit word address space into:
  - a word RAM, with read data returned combinationally in the same cycle and writes taking effect on the clock edge;
  - a memory-mapped peripheral page at 0xF0–0xFF containing GPIO, a compare timer and a byte TX FIFO with a valid/ready output.
- Read timing matches the single-cycle core: read data is valid in the same cycle the address is presented.

Parameters:
- RAM_WORDS, 240, number of RAM words. Must be ≤ 240 so the RAM never overlaps the peripheral page.
- GPIO_W, 8, GPIO in/out width (≤ 32).
- FIFO_DEPTH, 4, TX FIFO depth. Power of 2, ≥ 2.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- dmem_addr_i  in  8  word address from the core
- dmem_dt_i  in  32  write data from the core
- dmem_wr_i  in  1  write strobe; one write per cycle while high
- dmem_dt_o  out  32  read data, combinational from dmem_addr_i
- gpio_i  in  GPIO_W  asynchronous external inputs
- gpio_o  out  GPIO_W  registered outputs
- tx_dt_o  out  8  byte at the FIFO head
- tx_valid_o  out  1  FIFO not empty
- tx_ready_i  in  1  sink accepts; a pop occurs when tx_valid_o & tx_ready_i are high at the clock edge
- irq_o  out  1  equal to the sticky timer-match flag

Behaviour:
- Reset (asynchronous): all registers and FIFO pointers clear to 0.
  - gpio_o=0, tx_valid_o=0, irq_o=0.
  - tx_dt_o=0 while the FIFO is empty.
  - RAM contents are not reset.
- Address decode:
  - addr < RAM_WORDS → RAM.
  - RAM_WORDS ≤ addr < 0xF0 → unmapped: reads return 0, writes are ignored.
  - 0xF0–0xFF → peripheral page.
- Peripheral register map:
  - 0xF0 GPIO_OUT, RW.
  - 0xF1 GPIO_IN, RO. Two-flop synchronised gpio_i, so latency is 2 cycles.
  - 0xF2 TMR_CNT, RW, 32-bit.
  - 0xF3 TMR_CTRL, RW. Bit0 = enable.
  - 0xF4 TMR_CMP, RW, 32-bit. Resets to 0.
  - 0xF5 STATUS. Bit0 = match flag (W1C). Bit1 = TX overflow (W1C).
  - 0xF6 TX_DATA, WO. A write pushes dmem_dt_i[7:0]; reads return 0.
  - 0xF7 TX_STAT, RO. [3:0] = count, bit4 = full, bit5 = empty.
  - 0xF8–0xFF: read 0, writes ignored.
- Read data: RO fields are zero-extended to 32 bits; unused bits read 0.
- Timer, when enabled, each cycle:
  - if CNT == CMP: set the match flag and load CNT = 0 on the next edge;
  - otherwise CNT increments by 1, wrapping modulo 2^32.
  - When disabled, CNT holds.
- Timer simultaneous events:
  - A software write to TMR_CNT overrides both the increment and the reload in that cycle.
  - Hardware set of the match flag wins over a W1C in the same cycle.
- TX FIFO:
  - Push is accepted only if the FIFO is not full at the start of the cycle.
  - A push while full is dropped and sets the overflow flag, even if a pop occurs in the same cycle.
  - Simultaneous push and pop on a non-full, non-empty FIFO: count is unchanged, order is preserved.
  - Push into an empty FIFO: tx_valid_o rises the next cycle. There is no fall-through.
  - Pointers wrap modulo FIFO_DEPTH.
  - tx_dt_o holds steady while tx_valid_o=1 and tx_ready_i=0.
- Reset asserted mid-operation discards FIFO contents immediately. tx_valid_o drops asynchronously.

Decomposition:
- Package dmem_resp_pkg:
  - address constants: PERIPH_BASE=8'hF0 and each register offset;
  - STATUS and TX_STAT bit-index localparams.
- Natural sub-module: byte_fifo, a synchronous FIFO parameterised on DEPTH and width, with push/pop/full/empty/count. It is instantiated once for TX.

Test Plan:
- RAM path: write 0xDEADBEEF to 0x10, then read 0x10 the next cycle → dmem_dt_o=0xDEADBEEF. Reading 0xE0 with RAM_WORDS=200 → 0.
- GPIO: write 0x5A to 0xF0 → gpio_o=0x5A on the next edge. Drive gpio_i=0xA5 → reading 0xF1 returns 0xA5 after 2 clocks, not before.
- Timer: CMP=3, enable. Count sequence 0,1,2,3,0; the flag and irq_o rise on the edge after CNT==3. Write 0x1 to 0xF5 in the same cycle as a new match → flag stays 1.
- FIFO fill/overflow: with tx_ready_i=0, push 0x11,0x22,0x33,0x44 → TX_STAT = count 4, full. Push 0x55 → dropped, STATUS bit1=1.
- FIFO drain: raise tx_ready_i → tx_dt_o sequence 0x11,0x22,0x33,0x44 on consecutive cycles, then tx_valid_o=0, TX_STAT empty=1.
- Reset mid-drain: assert rst_ni low with 2 entries queued → tx_valid_o=0, gpio_o=0 and irq_o=0 immediately. After release, count=0.

Source files
------------

// File: rtl/dmem_resp_pkg.sv
// dmem_resp_pkg: address map and register bit positions for the data-memory responder.
// Latency: n/a (constants and a decode helper only).
// Backpressure: n/a.
package dmem_resp_pkg;

  // Peripheral page occupies the top 16 words of the 8-bit word address space
  localparam logic [7:0] PERIPH_BASE = 8'hF0;

  // Register offsets within the peripheral page
  localparam logic [3:0] OFF_GPIO_OUT = 4'h0;
  localparam logic [3:0] OFF_GPIO_IN  = 4'h1;
  localparam logic [3:0] OFF_TMR_CNT  = 4'h2;
  localparam logic [3:0] OFF_TMR_CTRL = 4'h3;
  localparam logic [3:0] OFF_TMR_CMP  = 4'h4;
  localparam logic [3:0] OFF_STATUS   = 4'h5;
  localparam logic [3:0] OFF_TX_DATA  = 4'h6;
  localparam logic [3:0] OFF_TX_STAT  = 4'h7;

  // TMR_CTRL bits
  localparam int TMR_CTRL_EN_BIT = 0;

  // STATUS bits (both write-one-to-clear)
  localparam int STATUS_MATCH_BIT = 0;
  localparam int STATUS_OVF_BIT   = 1;

  // TX_STAT fields
  localparam int TX_STAT_CNT_W     = 4;
  localparam int TX_STAT_FULL_BIT  = 4;
  localparam int TX_STAT_EMPTY_BIT = 5;

  // True when the word address falls inside the peripheral page
  function automatic logic is_periph(input logic [7:0] addr);
    return addr[7:4] == PERIPH_BASE[7:4];
  endfunction

endpackage

// File: rtl/dmem_resp_byte_fifo.sv
// byte_fifo: synchronous FIFO with push/pop, full/empty flags and occupancy count.
// Latency: a pushed entry appears at pop_dat the cycle after the push edge (no fall-through).
// Backpressure: push while full is dropped (caller watches full); pop while empty is ignored.
module byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Full is judged on the count at the start of the cycle, so a pop cannot make room for a same-cycle push
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Head is forced to zero when empty so stale storage never leaks out
  assign pop_dat = empty ? '0 : mem[rd_ptr];

  // Storage write; contents need no reset since they are only seen through the gated head
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/dmem_resp.sv
// dmem_resp: data-memory responder with word RAM plus GPIO, compare timer and TX byte FIFO page.
// Latency: reads combinational from address; writes land on the clock edge; GPIO_IN lags 2 cycles.
// Backpressure: none toward the core; TX FIFO pops on tx_valid_o & tx_ready_i, push when full is dropped and flagged.
module dmem_resp
  import dmem_resp_pkg::*;
#(
  parameter int RAM_WORDS  = 240,
  parameter int GPIO_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [7:0]        dmem_addr_i,
  input  logic [31:0]       dmem_dt_i,
  input  logic              dmem_wr_i,
  output logic [31:0]       dmem_dt_o,
  input  logic [GPIO_W-1:0] gpio_i,
  output logic [GPIO_W-1:0] gpio_o,
  output logic [7:0]        tx_dt_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic              irq_o
);

  localparam int         RAM_AW    = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [8:0] RAM_LIMIT = 9'(RAM_WORDS);
  localparam int         FCW       = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]       ram [RAM_WORDS];
  logic [RAM_AW-1:0] ram_idx;
  logic              in_ram;
  logic              periph;
  logic [3:0]        off;

  logic              wr_gpio, wr_cnt, wr_ctrl, wr_cmp, wr_status, wr_tx;

  logic [GPIO_W-1:0] gpio_s1, gpio_s2;
  logic [31:0]       tmr_cnt, tmr_cmp;
  logic              tmr_en;
  logic              tmr_hit;
  logic              match_flag, ovf_flag;

  logic              fifo_full, fifo_empty;
  logic [FCW-1:0]    fifo_count;
  logic [TX_STAT_CNT_W-1:0] tx_cnt;

  assign in_ram  = {1'b0, dmem_addr_i} < RAM_LIMIT;
  assign ram_idx = dmem_addr_i[RAM_AW-1:0];
  assign periph  = is_periph(dmem_addr_i);
  assign off     = dmem_addr_i[3:0];

  assign wr_gpio   = dmem_wr_i && periph && (off == OFF_GPIO_OUT);
  assign wr_cnt    = dmem_wr_i && periph && (off == OFF_TMR_CNT);
  assign wr_ctrl   = dmem_wr_i && periph && (off == OFF_TMR_CTRL);
  assign wr_cmp    = dmem_wr_i && periph && (off == OFF_TMR_CMP);
  assign wr_status = dmem_wr_i && periph && (off == OFF_STATUS);
  assign wr_tx     = dmem_wr_i && periph && (off == OFF_TX_DATA);

  // Match is evaluated on the current count; it drives both the reload and the sticky flag
  assign tmr_hit = tmr_en && (tmr_cnt == tmr_cmp);

  assign irq_o      = match_flag;
  assign tx_valid_o = !fifo_empty;
  assign tx_cnt     = TX_STAT_CNT_W'(fifo_count);

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .push     (wr_tx),
    .push_dat (dmem_dt_i[7:0]),
    .pop      (tx_ready_i),
    .pop_dat  (tx_dt_o),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // RAM write port; contents survive reset
  always_ff @(posedge clk_i) begin
    if (dmem_wr_i && in_ram) ram[ram_idx] <= dmem_dt_i;
  end

  // GPIO output register and two-flop input synchroniser
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gpio_o  <= '0;
      gpio_s1 <= '0;
      gpio_s2 <= '0;
    end else begin
      if (wr_gpio) gpio_o <= dmem_dt_i[GPIO_W-1:0];
      gpio_s1 <= gpio_i;
      gpio_s2 <= gpio_s1;
    end
  end

  // Timer: software write to CNT beats reload and increment; hardware flag set beats W1C
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmr_cnt    <= '0;
      tmr_cmp    <= '0;
      tmr_en     <= 1'b0;
      match_flag <= 1'b0;
      ovf_flag   <= 1'b0;
    end else begin
      if (wr_cnt)       tmr_cnt <= dmem_dt_i;
      else if (tmr_hit) tmr_cnt <= '0;
      else if (tmr_en)  tmr_cnt <= tmr_cnt + 32'd1;

      if (wr_ctrl) tmr_en  <= dmem_dt_i[TMR_CTRL_EN_BIT];
      if (wr_cmp)  tmr_cmp <= dmem_dt_i;

      if (tmr_hit)                                     match_flag <= 1'b1;
      else if (wr_status && dmem_dt_i[STATUS_MATCH_BIT]) match_flag <= 1'b0;

      if (wr_tx && fifo_full)                          ovf_flag <= 1'b1;
      else if (wr_status && dmem_dt_i[STATUS_OVF_BIT]) ovf_flag <= 1'b0;
    end
  end

  // Read mux: RAM, peripheral registers, zero for unmapped and write-only locations
  always_comb begin
    dmem_dt_o = '0;
    if (in_ram) begin
      dmem_dt_o = ram[ram_idx];
    end else if (periph) begin
      case (off)
        OFF_GPIO_OUT: dmem_dt_o = 32'(gpio_o);
        OFF_GPIO_IN:  dmem_dt_o = 32'(gpio_s2);
        OFF_TMR_CNT:  dmem_dt_o = tmr_cnt;
        OFF_TMR_CTRL: dmem_dt_o[TMR_CTRL_EN_BIT] = tmr_en;
        OFF_TMR_CMP:  dmem_dt_o = tmr_cmp;
        OFF_STATUS: begin
          dmem_dt_o[STATUS_MATCH_BIT] = match_flag;
          dmem_dt_o[STATUS_OVF_BIT]   = ovf_flag;
        end
        OFF_TX_STAT: begin
          dmem_dt_o[TX_STAT_CNT_W-1:0]  = tx_cnt;
          dmem_dt_o[TX_STAT_FULL_BIT]  = fifo_full;
          dmem_dt_o[TX_STAT_EMPTY_BIT] = fifo_empty;
        end
        default: dmem_dt_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_resp.sv
// tb_dmem_resp: directed scenarios plus random traffic checked against a behavioural model.
// Latency: model predicts combinational read data and next-edge register/FIFO state.
// Backpressure: tx_ready driven randomly; FIFO modelled as a queue.
module tb_dmem_resp;

  localparam int RAM_WORDS = 200;
  localparam int GPIO_W    = 8;
  localparam int DEPTH     = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  addr = 8'hF7;
  logic [31:0] dt_in = '0;
  logic        wr = 1'b0;
  logic [7:0]  gpio_in = '0;
  logic        ready = 1'b0;
  logic [31:0] rd;
  logic [7:0]  gpio_out;
  logic [7:0]  tx_dt;
  logic        tx_valid;
  logic        irq;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic [31:0] m_ram [256];
  bit          m_known [256];
  logic [7:0]  m_gout;
  logic [7:0]  m_ghist [$];
  logic [31:0] m_cnt, m_cmp;
  bit          m_en, m_flag, m_ovf;
  logic [7:0]  m_q [$];

  dmem_resp #(
    .RAM_WORDS  (RAM_WORDS),
    .GPIO_W     (GPIO_W),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .dmem_addr_i (addr),
    .dmem_dt_i   (dt_in),
    .dmem_wr_i   (wr),
    .dmem_dt_o   (rd),
    .gpio_i      (gpio_in),
    .gpio_o      (gpio_out),
    .tx_dt_o     (tx_dt),
    .tx_valid_o  (tx_valid),
    .tx_ready_i  (ready),
    .irq_o       (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_gout  = '0;
    m_ghist = '{8'd0, 8'd0};
    m_cnt   = '0;
    m_cmp   = '0;
    m_en    = 0;
    m_flag  = 0;
    m_ovf   = 0;
    m_q.delete();
  endtask

  function automatic bit model_read(input logic [7:0] a, output logic [31:0] v);
    v = '0;
    if (int'(a) < RAM_WORDS) begin
      v = m_ram[a];
      return m_known[a];
    end
    case (a)
      8'hF0: v = 32'(m_gout);
      8'hF1: v = 32'(m_ghist[1]);
      8'hF2: v = m_cnt;
      8'hF3: v = 32'(m_en);
      8'hF4: v = m_cmp;
      8'hF5: v = {30'd0, m_ovf, m_flag};
      8'hF7: v = (m_q.size() == 0 ? 32'h20 : 32'h0) |
                 (m_q.size() == DEPTH ? 32'h10 : 32'h0) | 32'(m_q.size());
      default: v = '0;
    endcase
    return 1;
  endfunction

  // Next-state of the model at a clock edge, from the inputs currently applied
  task automatic model_step();
    bit hit, push, full;
    hit  = m_en && (m_cnt == m_cmp);
    push = wr && (addr == 8'hF6);
    full = (m_q.size() == DEPTH);
    if (ready && m_q.size() > 0) void'(m_q.pop_front());
    if (push && !full) m_q.push_back(dt_in[7:0]);
    if (push && full) m_ovf = 1;
    else if (wr && addr == 8'hF5 && dt_in[1]) m_ovf = 0;
    if (hit) m_flag = 1;
    else if (wr && addr == 8'hF5 && dt_in[0]) m_flag = 0;
    if (wr && addr == 8'hF2) m_cnt = dt_in;
    else if (hit) m_cnt = '0;
    else if (m_en) m_cnt = m_cnt + 32'd1;
    if (wr && addr == 8'hF3) m_en = dt_in[0];
    if (wr && addr == 8'hF4) m_cmp = dt_in;
    if (wr && addr == 8'hF0) m_gout = dt_in[7:0];
    if (wr && int'(addr) < RAM_WORDS) begin
      m_ram[addr]   = dt_in;
      m_known[addr] = 1;
    end
    m_ghist.push_front(gpio_in);
    void'(m_ghist.pop_back());
  endtask

  task automatic compare();
    logic [31:0] v;
    bit known;
    known = model_read(addr, v);
    if (known) chk("rdata", rd, v);
    chk("gpio_o", 32'(gpio_out), 32'(m_gout));
    chk("tx_valid", 32'(tx_valid), 32'(m_q.size() != 0));
    chk("tx_dt", 32'(tx_dt), (m_q.size() != 0) ? 32'(m_q[0]) : 32'h0);
    chk("irq", 32'(irq), 32'(m_flag));
  endtask

  task automatic set_in(input logic [7:0] a, input logic [31:0] d, input logic w);
    addr  = a;
    dt_in = d;
    wr    = w;
    #1;
    compare();
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] pushes [4];
    pushes = '{8'h11, 8'h22, 8'h33, 8'h44};
    model_reset();

    // Reset state
    #1;
    chk("rst_gpio_o", 32'(gpio_out), 32'h0);
    chk("rst_tx_valid", 32'(tx_valid), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_tx_dt", 32'(tx_dt), 32'h0);
    chk("rst_txstat", rd, 32'h20);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // RAM and unmapped
    set_in(8'h10, 32'hDEADBEEF, 1); tick();
    set_in(8'h10, 32'h0, 0); chk("ram_rd", rd, 32'hDEADBEEF); tick();
    set_in(8'hE0, 32'h12345678, 1); tick();
    set_in(8'hE0, 32'h0, 0); chk("unmapped_rd", rd, 32'h0); tick();

    // GPIO out and synchronised in
    set_in(8'hF0, 32'h5A, 1); chk("gpio_o_pre", 32'(gpio_out), 32'h0); tick();
    chk("gpio_o_post", 32'(gpio_out), 32'h5A);
    gpio_in = 8'hA5;
    set_in(8'hF1, 32'h0, 0); chk("gpio_in_0clk", rd, 32'h0); tick();
    set_in(8'hF1, 32'h0, 0); chk("gpio_in_1clk", rd, 32'h0); tick();
    set_in(8'hF1, 32'h0, 0); chk("gpio_in_2clk", rd, 32'hA5); tick();

    // Timer count sequence and match
    set_in(8'hF4, 32'd3, 1); tick();
    set_in(8'hF2, 32'd0, 1); tick();
    set_in(8'hF3, 32'd1, 1); tick();
    for (int k = 0; k < 4; k++) begin
      set_in(8'hF2, 32'h0, 0);
      chk("tmr_seq", rd, 32'(k));
      chk("irq_pre", 32'(irq), 32'h0);
      tick();
    end
    set_in(8'hF2, 32'h0, 0); chk("tmr_wrap", rd, 32'h0); chk("irq_match", 32'(irq), 32'h1); tick();
    repeat (2) begin set_in(8'hF5, 32'h0, 0); tick(); end
    set_in(8'hF2, 32'h0, 0); chk("tmr_at_cmp", rd, 32'd3);
    set_in(8'hF5, 32'h1, 1); tick();
    set_in(8'hF5, 32'h0, 0); chk("w1c_vs_hit", rd, 32'h1); tick();
    set_in(8'hF3, 32'h0, 1); tick();
    set_in(8'hF5, 32'h1, 1); tick();
    set_in(8'hF5, 32'h0, 0); chk("w1c_clear", rd, 32'h0); chk("irq_cleared", 32'(irq), 32'h0); tick();

    // FIFO fill and overflow
    ready = 1'b0;
    for (int k = 0; k < 4; k++) begin set_in(8'hF6, 32'(pushes[k]), 1); tick(); end
    set_in(8'hF7, 32'h0, 0); chk("txstat_full", rd, 32'h14); chk("tx_head", 32'(tx_dt), 32'h11); tick();
    set_in(8'hF6, 32'h55, 1); tick();
    set_in(8'hF5, 32'h0, 0); chk("ovf_flag", rd, 32'h2); tick();
    set_in(8'hF6, 32'h0, 0); chk("tx_data_rd0", rd, 32'h0); tick();

    // FIFO drain
    ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_in(8'hF7, 32'h0, 0); chk("drain_dt", 32'(tx_dt), 32'(pushes[k])); tick();
    end
    set_in(8'hF7, 32'h0, 0); chk("drain_empty", rd, 32'h20); chk("drain_valid", 32'(tx_valid), 32'h0); tick();
    set_in(8'hF5, 32'h2, 1); tick();

    // Reset mid-drain with irq and GPIO active
    ready = 1'b0;
    set_in(8'hF4, 32'd0, 1); tick();
    set_in(8'hF2, 32'd0, 1); tick();
    set_in(8'hF3, 32'd1, 1); tick();
    set_in(8'hF6, 32'hAA, 1); tick();
    set_in(8'hF6, 32'hBB, 1); tick();
    set_in(8'hF7, 32'h0, 0);
    chk("pre_rst_cnt", rd, 32'h2);
    chk("pre_rst_irq", 32'(irq), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(tx_valid), 32'h0);
    chk("async_rst_gpio", 32'(gpio_out), 32'h0);
    chk("async_rst_irq", 32'(irq), 32'h0);
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    set_in(8'hF7, 32'h0, 0); chk("post_rst_txstat", rd, 32'h20); tick();

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      int sel;
      logic [7:0] a;
      logic [31:0] d;
      sel = $urandom_range(0, 9);
      if (sel < 4)       a = 8'($urandom_range(0, 15));
      else if (sel == 4) a = 8'($urandom_range(RAM_WORDS, 239));
      else if (sel == 9) a = 8'hF6;
      else               a = 8'($urandom_range(240, 255));
      d = $urandom;
      if (a == 8'hF2 || a == 8'hF4) d = d & 32'h7;
      gpio_in = 8'($urandom);
      ready = (i < 750) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 1) == 1);
      set_in(a, d, 1'($urandom_range(0, 1)));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
